// File: rtl/point_actuator_pkg.sv
// rtl/point_actuator_pkg.sv - shared constants for the twin-coil point actuator
package point_actuator_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_DRIVE   = 3'd1;
  localparam state_t ST_CONFIRM = 3'd2;
  localparam state_t ST_COOL    = 3'd3;
  localparam state_t ST_FAULT   = 3'd4;

  localparam int IN_CLK     = 0;
  localparam int IN_RST     = 1;
  localparam int IN_SET_CMD = 2;
  localparam int IN_FB_DIV  = 3;
  localparam int IN_FB_STR  = 4;
  localparam int IN_SPARE   = 5;
  localparam int IN_SEL_LO  = 6;
  localparam int IN_SEL_HI  = 7;

  localparam int OUT_COIL_DIV  = 0;
  localparam int OUT_COIL_STR  = 1;
  localparam int OUT_BUSY      = 2;
  localparam int OUT_FAULT     = 3;
  localparam int OUT_POS       = 4;
  localparam int OUT_POS_VALID = 5;

  localparam int PULSE_BASE_DEF = 4;
  localparam int SETTLE_MAX_DEF = 64;
  localparam int COOLDOWN_DEF   = 8;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with synchronous active-high reset
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/user_module_point_actuator.sv
// rtl/user_module_point_actuator.sv - timed coil pulse driver with end-of-travel confirmation
module user_module_point_actuator
  import point_actuator_pkg::*;
#(
  parameter int PULSE_BASE = PULSE_BASE_DEF,
  parameter int SETTLE_MAX = SETTLE_MAX_DEF,
  parameter int COOLDOWN   = COOLDOWN_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int PULSE_MAX = 4 * PULSE_BASE;
  localparam int MAX_A     = (PULSE_MAX > SETTLE_MAX) ? PULSE_MAX : SETTLE_MAX;
  localparam int CNT_MAX   = (MAX_A > COOLDOWN) ? MAX_A : COOLDOWN;
  localparam int CW        = $clog2(CNT_MAX + 1);

  logic clk;
  logic rst;
  assign clk = io_in[IN_CLK];
  assign rst = io_in[IN_RST];

  logic unused_ok;
  assign unused_ok = io_in[IN_SPARE];

  logic [4:0] raw;
  logic [4:0] syn;
  assign raw = {io_in[IN_SEL_HI:IN_SEL_LO], io_in[IN_FB_STR], io_in[IN_FB_DIV], io_in[IN_SET_CMD]};

  sync2 #(.WIDTH(5)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw),
    .q   (syn)
  );

  logic       cmd_s;
  logic       fb_div_s;
  logic       fb_str_s;
  logic [1:0] sel_s;
  assign cmd_s    = syn[0];
  assign fb_div_s = syn[1];
  assign fb_str_s = syn[2];
  assign sel_s    = syn[4:3];

  state_t        state;
  logic [CW-1:0] cnt;
  logic          target;
  logic          cmd_q;
  logic          coil_div;
  logic          coil_str;
  logic          busy;
  logic          fault;
  logic          pos;
  logic          pos_valid;

  logic [CW-1:0] pulse_len;
  logic          cnt_last;
  logic          fb_target;
  logic          fb_other;
  logic          start_throw;
  logic          confirm_fault;
  assign pulse_len = CW'(PULSE_BASE * (int'(sel_s) + 1));
  assign cnt_last  = (cnt <= CW'(1));
  assign fb_target = target ? fb_div_s : fb_str_s;
  assign fb_other  = target ? fb_str_s : fb_div_s;

  // FAULT is left only on a genuine edge of the synchronised command.
  assign start_throw = ((state == ST_IDLE) && (!pos_valid || (cmd_s != pos)))
                    || ((state == ST_FAULT) && (cmd_s != cmd_q));
  assign confirm_fault = (state == ST_CONFIRM)
                      && ((fb_div_s && fb_str_s) || (!(fb_target && !fb_other) && cnt_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      target    <= 1'b0;
      cmd_q     <= 1'b0;
      coil_div  <= 1'b0;
      coil_str  <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      pos       <= 1'b0;
      pos_valid <= 1'b0;
    end else begin
      cmd_q <= cmd_s;
      if (start_throw) begin
        state    <= ST_DRIVE;
        target   <= cmd_s;
        cnt      <= pulse_len;
        coil_div <= cmd_s;
        coil_str <= !cmd_s;
        busy     <= 1'b1;
        fault    <= 1'b0;
      end else if (confirm_fault) begin
        state     <= ST_FAULT;
        fault     <= 1'b1;
        pos_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_DRIVE: begin
            if (cnt_last) begin
              state    <= ST_CONFIRM;
              cnt      <= CW'(SETTLE_MAX);
              coil_div <= 1'b0;
              coil_str <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_CONFIRM: begin
            if (fb_target && !fb_other) begin
              state     <= ST_COOL;
              pos       <= target;
              pos_valid <= 1'b1;
              cnt       <= CW'(COOLDOWN);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_COOL: begin
            if (cnt_last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_IDLE, ST_FAULT: begin
          end
          default: begin
            state    <= ST_IDLE;
            coil_div <= 1'b0;
            coil_str <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    io_out                = 8'h00;
    io_out[OUT_COIL_DIV]  = coil_div;
    io_out[OUT_COIL_STR]  = coil_str;
    io_out[OUT_BUSY]      = busy;
    io_out[OUT_FAULT]     = fault;
    io_out[OUT_POS]       = pos;
    io_out[OUT_POS_VALID] = pos_valid;
  end

endmodule

// File: doc/user_module_point_actuator.md
# user_module_point_actuator

Point-motor driver that sits at the far end of the switch-diamond controller's `set_switch` command line. It turns each change of the commanded position into one timed coil pulse on the correct side of a twin-coil point motor. It then confirms end-of-travel through the motor's feedback contacts and reports position, busy and fault status back to the layout controller. One instance drives one point, so four instances serve one diamond.

## Interface
Parameters:
- `PULSE_BASE`, default 4: coil pulse unit in clocks; pulse length is P = `PULSE_BASE`*(sel+1).
- `SETTLE_MAX`, default 64: clocks allowed after the pulse for feedback to confirm.
- `COOLDOWN`, default 8: coil-off recovery clocks after a confirmed throw.

Ports (all sampled or driven on the rising edge of `io_in[0]`):
- `io_in[0]`, input, 1 bit: clock. This is the single clock.
- `io_in[1]`, input, 1 bit: reset. Synchronous, active-high.
- `io_in[2]`, input, 1 bit: `set_cmd`, the commanded position. 1 = diverging, 0 = straight.
- `io_in[3]`, input, 1 bit: `fb_div`, the diverging end-of-travel contact. Active-high.
- `io_in[4]`, input, 1 bit: `fb_str`, the straight end-of-travel contact. Active-high.
- `io_in[5]`, input, 1 bit: unused, ignored.
- `io_in[7:6]`, input, 2 bits: `sel`, the pulse length select.
- `io_out[0]`, output, 1 bit: `coil_div`, drives the diverging coil.
- `io_out[1]`, output, 1 bit: `coil_str`, drives the straight coil.
- `io_out[2]`, output, 1 bit: `busy`.
- `io_out[3]`, output, 1 bit: `fault`.
- `io_out[4]`, output, 1 bit: `pos`, the confirmed position.
- `io_out[5]`, output, 1 bit: `pos_valid`.
- `io_out[7:6]`, output, 2 bits: tied 0.

## Operation
Input synchronisation:
- `set_cmd`, `fb_div`, `fb_str` and `sel` each pass through a 2-flop synchroniser.
- All FSM decisions use the synchronised copies only.

States are IDLE, DRIVE, CONFIRM, COOL and FAULT.
- **IDLE:** if `pos_valid`=0 or `cmd_s` ≠ `pos`, then latch `target` = `cmd_s`, latch P from `sel_s`, and go to DRIVE. Otherwise stay in IDLE.
- **DRIVE:**
  - The coil selected by `target` is high. The other coil is 0.
  - After exactly P cycles, load the timer with `SETTLE_MAX` and go to CONFIRM.
- **CONFIRM:** both coils are 0. Exits are checked in this order:
  - `fb_div_s` and `fb_str_s` both high: go to FAULT.
  - Only the target feedback high: set `pos` = `target`, `pos_valid` = 1, load the timer with `COOLDOWN`, go to COOL.
  - Timer reaches 0: go to FAULT.
- **COOL:** both coils are 0. After `COOLDOWN` cycles, go to IDLE.
- **FAULT:**
  - `fault` = 1, `pos_valid` = 0, both coils 0.
  - Leave only on an edge of `cmd_s`: clear `fault`, latch the new `target`, go to DRIVE.
- `busy` = 1 in DRIVE, CONFIRM and COOL. It is 0 in IDLE and FAULT.
- `coil_div` and `coil_str` are never high in the same cycle under any input.
- A command change during DRIVE, CONFIRM or COOL is not aborted or re-targeted. IDLE re-evaluates after COOL, so the latest `cmd_s` wins.
- The feedback contacts are ignored outside CONFIRM. `fb_str` and `fb_div` are ignored in DRIVE and COOL.

## Timing
Reset:
- At the first edge with `io_in[1]`=1, every output is 0 and the state is IDLE.
- Reset mid-operation drops both coils at that same edge.
- After reset release, `pos_valid`=0, so the first IDLE cycle starts a throw to `cmd_s`.

Latency and cycle counts:
- A `set_cmd` change at the pin reaches `cmd_s` 2 edges later. The coil goes high on the following edge, 3 edges after the pin change.
- The coil is high for exactly P consecutive cycles: 4, 8, 12 or 16 at default `PULSE_BASE`.
- In CONFIRM, the timeout fires when no valid feedback arrives within `SETTLE_MAX` cycles after coil release. `fault` rises on the `SETTLE_MAX`-th CONFIRM cycle.
- `pos`/`pos_valid` update on the edge that leaves CONFIRM. `busy` falls `COOLDOWN` cycles later.

Arithmetic:
- One shared down-counter, width ceil(log2(max(4*`PULSE_BASE`, `SETTLE_MAX`, `COOLDOWN`)+1)).
- The counter is loaded on state entry and never wraps.

## Structure
- Shared package `point_actuator_pkg` holds:
  - the state enum;
  - the `io_in`/`io_out` bit-index constants;
  - the parameter defaults.
- Sub-module `sync2`: a parameterised-width two-flop synchroniser with synchronous reset, instantiated once at 5 bits.
- The FSM, counter and output registers stay in the top module. All outputs are registered.

## Test plan
- **Reset, then straight throw.** Stimulus: release reset with `set_cmd`=0, `sel`=0; raise `fb_str` 5 cycles after the coil drops. Required: `coil_str` high 4 cycles; `pos`=0 and `pos_valid`=1 set; `busy` falls 8 cycles later.
- **Diverging throw, long pulse.** Stimulus: `set_cmd` 0→1 with `sel`=3; raise `fb_div` 10 cycles after the coil drops. Required: `coil_div` rises 3 edges after the pin change and stays high exactly 16 cycles; `coil_str`=0 throughout; then `pos`=1.
- **Timeout.** Stimulus: throw with no feedback at all. Required: `fault`=1 on the 64th CONFIRM cycle; `pos_valid`=0; coils 0; a later `set_cmd` toggle clears `fault` and starts a new pulse.
- **Both contacts asserted.** Stimulus: `fb_div`=`fb_str`=1 during CONFIRM. Required: `fault`=1 on the next edge; coils stay 0.
- **Command toggle mid-DRIVE.** Stimulus: toggle `set_cmd` during DRIVE. Required: the current pulse length and coil are unchanged; after COOL, the opposite coil pulses.
- **Reset mid-DRIVE.** Stimulus: assert reset during DRIVE. Required: coils and all other outputs 0 at that edge; after release, a new full pulse runs.
